aes_stream_loader: RTL and testbench

- Upstream/downstream adapter for the 128-bit AES core. Assembles 32-bit stream words into the core's 128-bit `in_data` and `key`, and pulses `flag` to start the core.
- Waits a fixed core latency, captures `data_out`, and returns it as four 32-bit output words over valid/ready.
- Sits between the system word bus and the AES core.

---
 rtl/aes_stream_loader_if.sv | 27 ++
 rtl/aes_stream_loader.sv | 180 ++++++++++++++++++
 tb/tb_aes_stream_loader.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_stream_loader_if.sv
// Signal bundle shared by the word stream, the AES core and the loader.
// The loader connects through the slave modport; the surrounding system uses master.
interface aes_stream_loader_if;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_sel;
  logic [127:0] in_data;
  logic [127:0] key;
  logic         flag;
  logic [127:0] data_out;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_data;
  logic         m_last;
  logic         busy;

  modport slave (
    input  s_valid, s_data, s_sel, data_out, m_ready,
    output s_ready, in_data, key, flag, m_valid, m_data, m_last, busy
  );

  modport master (
    output s_valid, s_data, s_sel, data_out, m_ready,
    input  s_ready, in_data, key, flag, m_valid, m_data, m_last, busy
  );
endinterface

// File: rtl/aes_stream_loader.sv
// Packs 32-bit stream words into AES core key/plaintext, starts the core and streams the result back.
// Optional macro AES_LOADER_OVERLAP_EN stages the next plaintext block while the core is busy.
module aes_stream_loader #(
  parameter int CORE_LATENCY = 11,
  parameter int WORD_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  aes_stream_loader_if.slave bus
);
  localparam int         BLOCK_W  = 128;
  localparam logic [7:0] LAT_LOAD = 8'(CORE_LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_CAPTURE,
    ST_SEND
  } state_t;

  state_t                 state_q, state_d;
  logic [BLOCK_W-1:0]     dataBuf_q, dataBuf_d;
  logic [2:0]             dataCnt_q, dataCnt_d;
  logic [BLOCK_W-1:0]     key_q, key_d;
  logic [1:0]             keyCnt_q, keyCnt_d;
  logic                   keyValid_q, keyValid_d;
  logic [7:0]             latCnt_q, latCnt_d;
  logic [3:0][WORD_W-1:0] result_q, result_d;
  logic [1:0]             idx_q, idx_d;
`ifdef AES_LOADER_OVERLAP_EN
  logic [BLOCK_W-1:0]     inData_q, inData_d;
`endif

  logic              sReady;
  logic              sAccept;
  logic              dataSpace;
  logic              flag;
  logic              mValid;
  logic              mLast;
  logic [WORD_W-1:0] mData;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dataBuf_q  <= '0;
      dataCnt_q  <= '0;
      key_q      <= '0;
      keyCnt_q   <= '0;
      keyValid_q <= 1'b0;
      latCnt_q   <= '0;
      result_q   <= '0;
      idx_q      <= '0;
`ifdef AES_LOADER_OVERLAP_EN
      inData_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dataBuf_q  <= dataBuf_d;
      dataCnt_q  <= dataCnt_d;
      key_q      <= key_d;
      keyCnt_q   <= keyCnt_d;
      keyValid_q <= keyValid_d;
      latCnt_q   <= latCnt_d;
      result_q   <= result_d;
      idx_q      <= idx_d;
`ifdef AES_LOADER_OVERLAP_EN
      inData_q   <= inData_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    dataBuf_d  = dataBuf_q;
    dataCnt_d  = dataCnt_q;
    key_d      = key_q;
    keyCnt_d   = keyCnt_q;
    keyValid_d = keyValid_q;
    latCnt_d   = latCnt_q;
    result_d   = result_q;
    idx_d      = idx_q;
`ifdef AES_LOADER_OVERLAP_EN
    inData_d   = inData_q;
`endif
    flag      = 1'b0;
    mValid    = 1'b0;
    mLast     = 1'b0;
    mData     = '0;
    dataSpace = (dataCnt_q != 3'd4);

    // Key words only in IDLE; data words in IDLE, or while the core runs when overlap is built in.
    sReady = 1'b0;
    if (state_q == ST_IDLE) begin
      sReady = bus.s_sel | dataSpace;
    end
`ifdef AES_LOADER_OVERLAP_EN
    else if (state_q != ST_START) begin
      sReady = ~bus.s_sel & dataSpace;
    end
`endif
    sAccept = bus.s_valid & sReady;

    // Words shift in from the bottom so the first word of a group ends up in the top 32 bits.
    if (sAccept && bus.s_sel) begin
      key_d = {key_q[BLOCK_W-WORD_W-1:0], bus.s_data};
      if (keyCnt_q == 2'd0) begin
        keyValid_d = 1'b0;
      end
      if (keyCnt_q == 2'd3) begin
        keyValid_d = 1'b1;
      end
      keyCnt_d = keyCnt_q + 2'd1;
    end
    if (sAccept && !bus.s_sel) begin
      dataBuf_d = {dataBuf_q[BLOCK_W-WORD_W-1:0], bus.s_data};
      dataCnt_d = dataCnt_q + 3'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (dataCnt_d == 3'd4 && keyValid_d) begin
          state_d = ST_START;
`ifdef AES_LOADER_OVERLAP_EN
          inData_d  = dataBuf_d;
          dataCnt_d = '0;
`endif
        end
      end
      ST_START: begin
        flag     = 1'b1;
        latCnt_d = LAT_LOAD;
        state_d  = ST_WAIT;
      end
      // The edge leaving the last WAIT cycle is the one at which the core result is valid.
      ST_WAIT: begin
        if (latCnt_q == 8'd0) begin
          result_d = bus.data_out;
          state_d  = ST_CAPTURE;
        end else begin
          latCnt_d = latCnt_q - 8'd1;
        end
      end
      ST_CAPTURE: begin
`ifndef AES_LOADER_OVERLAP_EN
        dataCnt_d = '0;
`endif
        state_d = ST_SEND;
      end
      ST_SEND: begin
        mValid = 1'b1;
        mData  = result_q[2'd3 - idx_q];
        mLast  = (idx_q == 2'd3);
        if (bus.m_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.s_ready = sReady & ~rst;
  assign bus.flag    = flag;
  assign bus.m_valid = mValid;
  assign bus.m_data  = mData;
  assign bus.m_last  = mLast;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.key     = key_q;
`ifdef AES_LOADER_OVERLAP_EN
  assign bus.in_data = inData_q;
`else
  assign bus.in_data = dataBuf_q;
`endif

endmodule

// File: tb/tb_aes_stream_loader.sv
// Scoreboard bench for aes_stream_loader: word-level reference model, model AES core
// with exact-latency result window, directed FIPS-197 / backpressure / reset cases plus random blocks.
module tb_aes_stream_loader;
  localparam int           LAT      = 11;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst;

  aes_stream_loader_if bus ();

  aes_stream_loader #(
    .CORE_LATENCY(LAT),
    .WORD_W      (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total     = 0;
  int bad       = 0;
  int popCount  = 0;
  int flagCount = 0;

  logic [255:0] expStart[$];
  logic [32:0]  expOut[$];

  logic [31:0]  mKeyW[4];
  logic [31:0]  mPtW[4];
  int           mKeyCnt;
  int           mPtCnt;
  logic         mKeyValid;
  logic [127:0] mKey;

  logic         readyMode     = 1'b0;
  logic         directedReady = 1'b1;
  logic         prevFlag      = 1'b0;
  logic [255:0] startExp;
  int           coreCnt       = 0;
  logic [127:0] coreCt;

  // Stand-in for the AES core: the real vector for FIPS inputs, a keyed scramble otherwise.
  function automatic logic [127:0] cipherFn(input logic [127:0] p, input logic [127:0] k);
    if (p == FIPS_PT && k == FIPS_KEY) begin
      return FIPS_CT;
    end
    return p ^ {k[63:0], k[127:64]} ^ 128'h5a5a0f0f_3c3cc3c3_a5a5f0f0_96966969;
  endfunction

  function automatic void modelReset();
    mKeyCnt   = 0;
    mPtCnt    = 0;
    mKeyValid = 1'b0;
  endfunction

  // Reference model at word granularity: a block is due whenever four data words and a full key are held.
  function automatic void modelAccept(input logic sel, input logic [31:0] w);
    logic [127:0] pt;
    logic [127:0] ct;
    if (sel) begin
      if (mKeyCnt == 0) mKeyValid = 1'b0;
      mKeyW[mKeyCnt] = w;
      mKeyCnt++;
      if (mKeyCnt == 4) begin
        mKeyCnt   = 0;
        mKeyValid = 1'b1;
        mKey      = {mKeyW[0], mKeyW[1], mKeyW[2], mKeyW[3]};
      end
    end else if (mPtCnt < 4) begin
      mPtW[mPtCnt] = w;
      mPtCnt++;
    end
    if (mPtCnt == 4 && mKeyValid) begin
      pt     = {mPtW[0], mPtW[1], mPtW[2], mPtW[3]};
      mPtCnt = 0;
      expStart.push_back({pt, mKey});
      ct = cipherFn(pt, mKey);
      for (int i = 0; i < 4; i++) begin
        expOut.push_back({((i == 3) ? 1'b1 : 1'b0), ct[127-32*i -: 32]});
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic sel, input logic [31:0] word);
    int waited = 0;
    bus.s_valid = 1'b1;
    bus.s_sel   = sel;
    bus.s_data  = word;
    @(negedge clk);
    while (!bus.s_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.s_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL s_ready_timeout: got s_ready=0 for sel=%b word=%h, want 1", sel, word);
    end else begin
      modelAccept(sel, word);
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic waitPops(input int target);
    int n = 0;
    while (popCount < target && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (popCount < target) begin
      bad++;
      $display("[TB] FAIL pop_timeout: got %0d words, want %0d", popCount, target);
    end
  endtask

  // Output monitor: every presented word is compared against the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.m_valid) begin
        total++;
        if (expOut.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_m_valid: got m_data=%h, want no output", bus.m_data);
        end else if ({bus.m_last, bus.m_data} !== expOut[0]) begin
          bad++;
          $display("[TB] FAIL out_word: got last=%b data=%h, want last=%b data=%h",
                   bus.m_last, bus.m_data, expOut[0][32], expOut[0][31:0]);
        end
        if (bus.m_ready && expOut.size() != 0) begin
          void'(expOut.pop_front());
          popCount++;
        end
      end
    end
  end

  // Start monitor: single-cycle flag with the operands the model predicted.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.flag) begin
        flagCount++;
        total++;
        if (prevFlag) begin
          bad++;
          $display("[TB] FAIL flag_width: got flag high 2+ cycles, want 1");
        end else if (expStart.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_flag: got flag=1, want 0");
        end else begin
          startExp = expStart.pop_front();
          if ({bus.in_data, bus.key} !== startExp) begin
            bad++;
            $display("[TB] FAIL start_operands: got in_data=%h key=%h, want in_data=%h key=%h",
                     bus.in_data, bus.key, startExp[255:128], startExp[127:0]);
          end
        end
      end
      prevFlag = bus.flag;
    end
  end

  // Model core: result is valid only during cycle flag+LAT, garbage otherwise.
  initial begin
    bus.data_out = '0;
    forever begin
      @(negedge clk);
      if (bus.flag) begin
        coreCnt = LAT;
        coreCt  = cipherFn(bus.in_data, bus.key);
      end
      @(posedge clk);
      #1;
      if (coreCnt == 1) bus.data_out = coreCt;
      else bus.data_out = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (coreCnt > 0) coreCnt--;
    end
  end

  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.m_ready = readyMode ? directedReady : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, want test end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] kv;
    logic [127:0] pv;
    int           flagsBefore;
    int           popBase;
    int           ki;
    int           di;
    int           gap;
    logic         newKey;

    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_sel   = 1'b0;
    bus.s_data  = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_s_ready", bus.s_ready, 1);
    repeat (4) @(negedge clk);
    checkOutput("idle_no_flag", flagCount, 0);

    // Partial load, then asynchronous reset mid-cycle.
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 32'h00010203);
    applyStimulus(1'b1, 32'h04050607);
    applyStimulus(1'b0, 32'h00112233);
    applyStimulus(1'b0, 32'h44556677);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_in_data", bus.in_data, 0);
    checkOutput("rst_key", bus.key, 0);
    checkOutput("rst_ctrl", {bus.s_ready, bus.flag, bus.m_valid, bus.m_last, bus.busy}, 0);
    checkOutput("rst_m_data", bus.m_data, 0);
    expStart.delete();
    expOut.delete();
    modelReset();
    @(posedge clk);
    #1 rst = 1'b0;

    // FIPS-197 vector with 5 cycles of backpressure on the second output word.
    readyMode     = 1'b1;
    directedReady = 1'b1;
    kv = FIPS_KEY;
    pv = FIPS_PT;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, kv[127-32*i -: 32]);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, pv[127-32*i -: 32]);
    waitPops(1);
    @(posedge clk);
    #1 directedReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_word1", {bus.m_valid, bus.m_data}, {1'b1, 32'h6a7b0430});
    end
    directedReady = 1'b1;
    waitPops(4);
    @(negedge clk);
    checkOutput("m_valid_after_block", bus.m_valid, 0);

    // Key reuse: data only.
    readyMode = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, $urandom());
    @(negedge clk);
    checkOutput("reuse_start", {bus.busy, bus.flag, bus.m_valid}, {1'b1, 1'b1, 1'b0});
    waitPops(8);

    // Reset three cycles after flag discards the block and the key.
    @(posedge clk);
    #1;
    flagsBefore = flagCount;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, $urandom());
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_wait_ctrl", {bus.busy, bus.m_valid, bus.flag}, 0);
    checkOutput("rst_wait_flag_seen", flagCount, flagsBefore + 1);
    expOut.delete();
    modelReset();
    @(posedge clk);
    #1 rst = 1'b0;

    // Data before key: no start until the key is reloaded; stalled words are ignored.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, $urandom());
    bus.s_valid = 1'b1;
    bus.s_sel   = 1'b0;
    bus.s_data  = 32'hdeadbeef;
    @(negedge clk);
    checkOutput("full_s_ready_data", bus.s_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.s_data = $urandom();
    end
    bus.s_valid = 1'b0;
    bus.s_sel   = 1'b1;
    #1;
    checkOutput("full_s_ready_key", bus.s_ready, 1);
    checkOutput("no_key_no_flag", flagCount, flagsBefore + 1);
    @(posedge clk);
    #1;
    popBase = popCount;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, kv[127-32*i -: 32]);
    @(negedge clk);
    checkOutput("flag_after_key", bus.flag, 1);
    waitPops(popBase + 4);

    // Random blocks with interleaved key/data words and random backpressure.
    @(posedge clk);
    #1;
    for (int b = 0; b < 16; b++) begin
      newKey = (b == 0) || ($urandom_range(0, 1) == 1);
      ki = newKey ? 0 : 4;
      di = 0;
      while (ki < 4 || di < 4) begin
        if (ki < 4 && (di == 4 || $urandom_range(0, 1) == 1)) begin
          applyStimulus(1'b1, $urandom());
          ki++;
        end else begin
          applyStimulus(1'b0, $urandom());
          di++;
        end
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end

    for (int n = 0; n < 2000 && expOut.size() != 0; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput("drain_out", expOut.size(), 0);
    checkOutput("drain_start", expStart.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
